// File: rtl/controlador_display_7seg.sv
// 4-digit common-anode multiplexed 7-segment driver fed from a packed BCD word.
// The design has a refresh prescaler, a digit scan counter, and frame-synchronous
// double buffering. It also has guard blanking, optional leading-zero blanking,
// and registered outputs.
module controlador_display_7seg #(
    parameter int unsigned DIV      = 50000,
    parameter int unsigned GUARD    = 2,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   disp;

    logic          tick_c;
    logic          frame_end_c;
    logic          guard_c;
    logic [3:0]    digit_c;
    logic [3:0]    lz_blank_c;
    logic [6:0]    seg_nxt_c;
    logic          dp_nxt_c;
    logic [3:0]    an_nxt_c;

    // Active-low segment pattern (g..a) for one digit; values above 9 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick_c      = (cnt == CNT_MAX);
    assign frame_end_c = tick_c && (idx == 2'd3);
    assign guard_c     = (cnt < GUARD_C);
    assign digit_c     = disp[{idx, 2'b00} +: 4];

    // Leading-zero mask: a digit blanks when it and every higher digit are zero.
    always_comb begin
        lz_blank_c = 4'b0000;
        if (BLANK_LZ != 0) begin
            lz_blank_c[3] = (disp[15:12] == 4'd0);
            lz_blank_c[2] = lz_blank_c[3] && (disp[11:8] == 4'd0);
            lz_blank_c[1] = lz_blank_c[2] && (disp[7:4] == 4'd0);
        end
    end

    // Next output values from the current scan state.
    always_comb begin
        seg_nxt_c = 7'b1111111;
        dp_nxt_c  = 1'b1;
        an_nxt_c  = 4'b1111;
        if (!guard_c && !lz_blank_c[idx]) begin
            seg_nxt_c = decode(digit_c);
            dp_nxt_c  = ~dp_mask[idx];
            an_nxt_c  = ~(4'b0001 << idx);
        end
    end

    // Prescaler, scan index, capture buffer and frame-synchronous display buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 2'd0;
            shadow <= 16'h0000;
            disp   <= 16'h0000;
        end else begin
            cnt <= tick_c ? '0 : cnt + CW'(1);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                shadow <= bcd;
            end
            if (frame_end_c) begin
                disp <= load ? bcd : shadow;
            end
        end
    end

    // Registered segment, decimal point and anode drivers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt_c;
            dp  <= dp_nxt_c;
            an  <= an_nxt_c;
        end
    end

endmodule

// File: tb/tb_controlador_display_7seg.sv
// Randomized bench for controlador_display_7seg. Two instances share the same
// stimulus, one with leading-zero blanking and one without. Both are compared
// each cycle against a model that tracks time since reset as plain arithmetic.
`timescale 1ns/1ps
module tb_controlador_display_7seg;

    localparam int unsigned DIV   = 4;
    localparam int unsigned GUARD = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load;
    logic [3:0]  dp_mask;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    logic [6:0]  e_seg [2];
    logic        e_dp  [2];
    logic [3:0]  e_an  [2];
    logic [6:0]  seg_tab [16];

    controlador_display_7seg #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .dp_mask(dp_mask),
        .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    controlador_display_7seg #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1)) u_lz (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .dp_mask(dp_mask),
        .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected output for one instance given the model's pre-edge state.
    task automatic predict(input int k, input bit lz);
        int pos;
        int slot;
        logic [15:0] upper;
        logic [3:0]  d;
        pos   = t % DIV;
        slot  = (t / DIV) % 4;
        upper = m_disp >> (4 * slot);
        d     = upper[3:0];
        if (pos < GUARD || (lz && slot > 0 && upper == 16'h0000)) begin
            e_seg[k] = 7'b1111111;
            e_dp[k]  = 1'b1;
            e_an[k]  = 4'b1111;
        end else begin
            e_seg[k] = seg_tab[d];
            e_dp[k]  = ~dp_mask[slot];
            e_an[k]  = 4'b1111 ^ 4'(1 << slot);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        if (!rst_n) begin
            t        = 0;
            m_shadow = 16'h0000;
            m_disp   = 16'h0000;
            for (int k = 0; k < 2; k++) begin
                e_seg[k] = 7'b1111111;
                e_dp[k]  = 1'b1;
                e_an[k]  = 4'b1111;
            end
        end else begin
            predict(0, 1'b0);
            predict(1, 1'b1);
            if ((t % DIV) == DIV - 1 && ((t / DIV) % 4) == 3) begin
                m_disp = load ? bcd : m_shadow;
            end
            if (load) begin
                m_shadow = bcd;
            end
            t++;
        end
    endtask

    task automatic compare_outputs();
        check("seg_nolz", 32'(seg_a), 32'(e_seg[0]));
        check("dp_nolz",  32'(dp_a),  32'(e_dp[0]));
        check("an_nolz",  32'(an_a),  32'(e_an[0]));
        check("seg_lz",   32'(seg_b), 32'(e_seg[1]));
        check("dp_lz",    32'(dp_b),  32'(e_dp[1]));
        check("an_lz",    32'(an_b),  32'(e_an[1]));
        check("one_anode", 32'($countones(~an_a) <= 1 && $countones(~an_b) <= 1), 32'd1);
    endtask

    // Apply inputs, clock once, then compare on the falling edge.
    task automatic step(input logic r, input logic l, input logic [15:0] b, input logic [3:0] m);
        rst_n   = r;
        load    = l;
        bcd     = b;
        dp_mask = m;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n, input logic [3:0] m);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'hDEAD, m);
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    v[4*k +: 4] = 4'd0;
                2:       v[4*k +: 4] = 4'($urandom_range(0, 9));
                default: v[4*k +: 4] = 4'($urandom_range(0, 15));
            endcase
        end
        return v;
    endfunction

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
        t = 0; m_shadow = '0; m_disp = '0;

        // Reset, with a load that must be discarded
        step(1'b0, 1'b1, 16'h9999, 4'b0000);
        step(1'b0, 1'b0, 16'h0000, 4'b0000);
        check("rst_an",  32'(an_b),  32'hF);
        check("rst_seg", 32'(seg_b), 32'h7F);
        check("rst_dp",  32'(dp_b),  32'h1);

        // Idle frame after reset: digit 0 shows "0"
        idle(4 * DIV, 4'b0000);

        // Basic pattern, then two frames of display
        step(1'b1, 1'b1, 16'h1234, 4'b0000);
        idle(9 * DIV, 4'b0100);

        // Leading zeros
        step(1'b1, 1'b1, 16'h0050, 4'b0000);
        idle(8 * DIV, 4'b0000);
        step(1'b1, 1'b1, 16'h0000, 4'b0000);
        idle(8 * DIV, 4'b0000);

        // Tearing: wait for a frame, then load new data mid-frame at idx=1
        step(1'b1, 1'b1, 16'h1111, 4'b0000);
        while ((t % (4 * DIV)) != DIV + 1) step(1'b1, 1'b0, 16'h0000, 4'b0000);
        idle(4 * DIV, 4'b0000);
        step(1'b1, 1'b1, 16'h2222, 4'b0000);
        idle(8 * DIV, 4'b0000);

        // Invalid digits count as non-zero
        step(1'b1, 1'b1, 16'hA9F0, 4'b1010);
        idle(8 * DIV, 4'b1010);

        // Reset mid-slot at idx=2 with a pending load
        step(1'b1, 1'b1, 16'h4321, 4'b0000);
        while (((t / DIV) % 4) != 2 || (t % DIV) != 2) step(1'b1, 1'b0, 16'h0000, 4'b0000);
        step(1'b0, 1'b0, 16'h0000, 4'b0000);
        check("midrst_an", 32'(an_a), 32'hF);
        idle(8 * DIV, 4'b1111);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) == 0),
                 rnd_bcd(), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
